mem_access: RTL and testbench

Memory/write-back stage of the core, downstream of the execute stage. It accepts one execute result at a time, performs the data-memory load or store over a request/acknowledge bus, and drives the register-file write-back port. It provides byte/halfword/word sizing, sign and zero extension, store byte strobes, misalignment detection and a bus timeout.

---
 rtl/mem_access.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory/write-back stage: takes one execute result, runs the data-memory
// load/store over a req/ack bus and produces the register write-back pulse.
module mem_access #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data,
  input  logic [31:0] store_v,
  input  logic        mem_read_enabled,
  input  logic        mem_write_enabled,
  input  logic [2:0]  mem_size,
  input  logic        reg_write_enabled,
  input  logic [5:0]  reg_write_dest,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_enabled,
  output logic [5:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [5:0]    dest_q, dest_d;
  logic          rwe_q, rwe_d;
  logic          wb_en_q, wb_en_d;
  logic [5:0]    wb_dest_q, wb_dest_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;

  logic          is_mem, mis_in;
  logic [2:0]    sz_n;
  logic [3:0]    st_strb;
  logic [31:0]   st_wdata;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_val;

  // Unsupported size codes collapse to word so the rest only sees B/H/W/BU/HU.
  always_comb begin
    case (mem_size)
      3'b000, 3'b001, 3'b100, 3'b101: sz_n = mem_size;
      default:                        sz_n = 3'b010;
    endcase
  end

  always_comb begin
    is_mem = mem_read_enabled | mem_write_enabled;
    mis_in = ((sz_n[1:0] == 2'b01) && data[0]) ||
             ((sz_n == 3'b010) && (data[1:0] != 2'b00));
    case (sz_n[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << data[1:0];
        st_wdata = {4{store_v[7:0]}};
      end
      2'b01: begin
        st_strb  = data[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_v[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = store_v;
      end
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_b = bus_rdata[7:0];
      2'd1:    ld_b = bus_rdata[15:8];
      2'd2:    ld_b = bus_rdata[23:16];
      default: ld_b = bus_rdata[31:24];
    endcase
    ld_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    size_d    = size_q;
    dest_d    = dest_q;
    rwe_d     = rwe_q;
    wb_en_d   = 1'b0;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_en_d   = reg_write_enabled && (reg_write_dest != 6'd0);
            wb_dest_d = reg_write_dest;
            wb_data_d = data;
          end else if (mis_in) begin
            mis_d = 1'b1;
          end else begin
            state_d = BUS;
            cnt_d   = '0;
            addr_d  = {data[31:2], 2'b00};
            off_d   = data[1:0];
            wdata_d = st_wdata;
            we_d    = mem_write_enabled;
            wstrb_d = mem_write_enabled ? st_strb : 4'b0000;
            size_d  = sz_n;
            dest_d  = reg_write_dest;
            rwe_d   = reg_write_enabled;
          end
        end
      end
      BUS: begin
        // An ack in the would-be timeout cycle still completes the access.
        if (bus_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_en_d   = rwe_q && (dest_q != 6'd0);
            wb_dest_d = dest_q;
            wb_data_d = ld_val;
          end
        end else if (cnt_q == CW'(BUS_TIMEOUT - 1)) begin
          state_d = IDLE;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      dest_q    <= '0;
      rwe_q     <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      size_q    <= size_d;
      dest_q    <= dest_d;
      rwe_q     <= rwe_d;
      wb_en_q   <= wb_en_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign bus_req    = (state_q == BUS);
  assign bus_we     = bus_req & we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = bus_req ? wstrb_q : 4'b0000;
  assign wb_enabled = wb_en_q;
  assign wb_dest    = wb_dest_q;
  assign wb_data    = wb_data_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a short bus timeout.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data;
  logic [31:0] store_v;
  logic        mem_read_enabled;
  logic        mem_write_enabled;
  logic [2:0]  mem_size;
  logic        reg_write_enabled;
  logic [5:0]  reg_write_dest;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        wb_enabled;
  logic [5:0]  wb_dest;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        bus_error;

  int n_chk  = 0;
  int n_pass = 0;

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .store_v(store_v), .mem_read_enabled(mem_read_enabled),
    .mem_write_enabled(mem_write_enabled), .mem_size(mem_size),
    .reg_write_enabled(reg_write_enabled), .reg_write_dest(reg_write_dest),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .wb_enabled(wb_enabled), .wb_dest(wb_dest),
    .wb_data(wb_data), .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one op for a single transfer edge; returns 1 time unit into cycle N+1.
  task automatic issue(input logic mr, input logic mw, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] sv,
                       input logic rwe, input logic [5:0] dst);
    @(negedge clk);
    data = a; store_v = sv; mem_read_enabled = mr; mem_write_enabled = mw;
    mem_size = sz; reg_write_enabled = rwe; reg_write_dest = dst; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mem_read_enabled = 1'b0; mem_write_enabled = 1'b0;
  endtask

  // Hold off for 'waits' cycles, then ack for one cycle; returns in cycle M+1.
  task automatic ack_after(input int waits, input logic [31:0] rd);
    repeat (waits) step();
    bus_rdata = rd; bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data = '0; store_v = '0;
    mem_read_enabled = 1'b0; mem_write_enabled = 1'b0; mem_size = '0;
    reg_write_enabled = 1'b0; reg_write_dest = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_en", 32'(wb_enabled), 32'd0);
    @(negedge clk); rst = 1'b0;
    step();

    // ALU write-back
    issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 1'b1, 6'd5);
    chk("alu_wb_en", 32'(wb_enabled), 32'd1);
    chk("alu_wb_dest", 32'(wb_dest), 32'd5);
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    chk("alu_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("alu_wb_pulse", 32'(wb_enabled), 32'd0);
    issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 1'b1, 6'd0);
    chk("alu_dest0", 32'(wb_enabled), 32'd0);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_00AA, 32'h0, 1'b1, 6'd32);
    chk("alu_f0_en", 32'(wb_enabled), 32'd1);
    chk("alu_f0_dest", 32'(wb_dest), 32'd32);

    // LB / LBU
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 1'b1, 6'd7);
    chk("lb_req", 32'(bus_req), 32'd1);
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_we", 32'(bus_we), 32'd0);
    chk("lb_wstrb", 32'(bus_wstrb), 32'd0);
    chk("lb_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("lb_wait_no_wb", 32'(wb_enabled), 32'd0);
    ack_after(1, 32'h80FF_0000);
    chk("lb_wb_en", 32'(wb_enabled), 32'd1);
    chk("lb_wb_dest", 32'(wb_dest), 32'd7);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_req_low", 32'(bus_req), 32'd0);
    chk("lb_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("lb_wb_pulse", 32'(wb_enabled), 32'd0);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 1'b1, 6'd7);
    ack_after(2, 32'h80FF_0000);
    chk("lbu_wb_data", wb_data, 32'h0000_0080);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 1'b1, 6'd8);
    ack_after(0, 32'h80FF_0000);
    chk("lh_wb_data", wb_data, 32'hFFFF_80FF);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_1000, 32'h0, 1'b1, 6'd8);
    ack_after(0, 32'h1234_9876);
    chk("lhu_wb_data", wb_data, 32'h0000_9876);

    // Stores
    issue(1'b0, 1'b1, 3'b000, 32'h0000_2002, 32'hAABB_CCDD, 1'b0, 6'd0);
    chk("sb_we", 32'(bus_we), 32'd1);
    chk("sb_addr", bus_addr, 32'h0000_2000);
    chk("sb_wstrb", 32'(bus_wstrb), 32'h4);
    chk("sb_wdata", bus_wdata, 32'hDDDD_DDDD);
    ack_after(0, 32'h0);
    chk("sb_no_wb", 32'(wb_enabled), 32'd0);
    chk("sb_in_ready", 32'(in_ready), 32'd1);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hAABB_CCDD, 1'b0, 6'd0);
    chk("sh_wstrb", 32'(bus_wstrb), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hCCDD_CCDD);
    ack_after(1, 32'h0);
    chk("sh_no_wb", 32'(wb_enabled), 32'd0);
    issue(1'b1, 1'b1, 3'b010, 32'h0000_2004, 32'hAABB_CCDD, 1'b1, 6'd3);
    chk("sw_we", 32'(bus_we), 32'd1);
    chk("sw_wstrb", 32'(bus_wstrb), 32'hF);
    chk("sw_wdata", bus_wdata, 32'hAABB_CCDD);
    ack_after(0, 32'hFFFF_FFFF);
    chk("sw_no_wb", 32'(wb_enabled), 32'd0);

    // Misalignment
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1'b1, 6'd4);
    chk("mis_lw_pulse", 32'(misaligned), 32'd1);
    chk("mis_lw_req", 32'(bus_req), 32'd0);
    chk("mis_lw_ready", 32'(in_ready), 32'd1);
    chk("mis_lw_no_wb", 32'(wb_enabled), 32'd0);
    step();
    chk("mis_lw_once", 32'(misaligned), 32'd0);
    chk("mis_lw_req2", 32'(bus_req), 32'd0);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_1001, 32'h0, 1'b1, 6'd4);
    chk("mis_size011", 32'(misaligned), 32'd1);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_1003, 32'h0, 1'b0, 6'd0);
    chk("mis_sh_odd", 32'(misaligned), 32'd1);

    // Ack while idle is ignored
    bus_rdata = 32'hDEAD_BEEF; bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    chk("idle_ack_no_wb", 32'(wb_enabled), 32'd0);
    chk("idle_ack_ready", 32'(in_ready), 32'd1);

    // Timeout with no ack
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 6'd9);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_%0d", i), 32'(bus_req), 32'd1);
      chk($sformatf("to_noerr_%0d", i), 32'(bus_error), 32'd0);
      step();
    end
    chk("to_req_low", 32'(bus_req), 32'd0);
    chk("to_err", 32'(bus_error), 32'd1);
    chk("to_ready", 32'(in_ready), 32'd1);
    chk("to_no_wb", 32'(wb_enabled), 32'd0);
    step();
    chk("to_err_pulse", 32'(bus_error), 32'd0);

    // Ack on the final cycle beats the timeout
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 6'd9);
    ack_after(3, 32'h5555_AAAA);
    chk("late_ack_wb_en", 32'(wb_enabled), 32'd1);
    chk("late_ack_wb_data", wb_data, 32'h5555_AAAA);
    chk("late_ack_no_err", 32'(bus_error), 32'd0);
    step();
    chk("late_ack_no_err2", 32'(bus_error), 32'd0);

    // Reset in the middle of a bus access
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b1, 6'd10);
    chk("rstb_req_pre", 32'(bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstb_req_drop", 32'(bus_req), 32'd0);
    chk("rstb_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    bus_rdata = 32'h1111_2222; bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstb_no_wb_%0d", i), 32'(wb_enabled), 32'd0);
      chk($sformatf("rstb_no_err_%0d", i), 32'(bus_error), 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
